// File: rtl/easyaxi_slv_wr_ctrl.sv
// Slave-side AXI write controller: one AW at a time, W beats land in a
// byte-strobed register-file memory, then a single B response is returned.
module easyaxi_slv_wr_ctrl #(
   parameter int AXI_ID_W    = 4,
   parameter int AXI_ADDR_W  = 32,
   parameter int AXI_DATA_W  = 32,
   parameter int AXI_LEN_W   = 8,
   parameter int AXI_SIZE_W  = 3,
   parameter int AXI_BURST_W = 2,
   parameter int AXI_RESP_W  = 2,
   parameter int AXI_USER_W  = 4,
   parameter int MEM_DEPTH   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      axi_slv_awvalid,
   output logic                      axi_slv_awready,
   input  logic [AXI_ID_W-1:0]       axi_slv_awid,
   input  logic [AXI_ADDR_W-1:0]     axi_slv_awaddr,
   input  logic [AXI_LEN_W-1:0]      axi_slv_awlen,
   input  logic [AXI_SIZE_W-1:0]     axi_slv_awsize,
   input  logic [AXI_BURST_W-1:0]    axi_slv_awburst,
   input  logic [AXI_USER_W-1:0]     axi_slv_awuser,
   input  logic                      axi_slv_wvalid,
   output logic                      axi_slv_wready,
   input  logic [AXI_DATA_W-1:0]     axi_slv_wdata,
   input  logic [AXI_DATA_W/8-1:0]   axi_slv_wstrb,
   input  logic                      axi_slv_wlast,
   output logic                      axi_slv_bvalid,
   input  logic                      axi_slv_bready,
   output logic [AXI_ID_W-1:0]       axi_slv_bid,
   output logic [AXI_RESP_W-1:0]     axi_slv_bresp,
   output logic [AXI_USER_W-1:0]     axi_slv_buser,
   input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
   output logic [AXI_DATA_W-1:0]     dbg_rdata
);

   localparam int STRB_W   = AXI_DATA_W / 8;
   localparam int ADDR_LSB = $clog2(STRB_W);
   localparam int IDX_W    = $clog2(MEM_DEPTH);
   localparam logic [AXI_ADDR_W-1:0] MEM_BYTES = AXI_ADDR_W'(MEM_DEPTH * STRB_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [AXI_ID_W-1:0]     id_q;
   logic [AXI_ADDR_W-1:0]   addr_q;
   logic [AXI_LEN_W-1:0]    len_q;
   logic [AXI_SIZE_W-1:0]   size_q;
   logic [AXI_BURST_W-1:0]  burst_q;
   logic [AXI_USER_W-1:0]   user_q;
   logic [AXI_LEN_W-1:0]    cnt_q;
   logic                    slverr_q;
   logic                    decerr_q;
   logic [AXI_DATA_W-1:0]   mem [MEM_DEPTH];

   logic             aw_hs, w_hs, b_hs, last_beat;
   logic [IDX_W-1:0] idx;

   assign aw_hs     = axi_slv_awvalid & axi_slv_awready;
   assign w_hs      = axi_slv_wvalid & axi_slv_wready;
   assign b_hs      = axi_slv_bvalid & axi_slv_bready;
   assign last_beat = (cnt_q == len_q);
   assign idx       = addr_q[ADDR_LSB +: IDX_W];

   assign axi_slv_awready = (state_q == IDLE);
   assign axi_slv_wready  = (state_q == DATA);
   assign axi_slv_bvalid  = (state_q == RESP);
   assign axi_slv_bid     = id_q;
   assign axi_slv_buser   = user_q;
   assign axi_slv_bresp   = decerr_q ? AXI_RESP_W'(3) :
                            slverr_q ? AXI_RESP_W'(2) : AXI_RESP_W'(0);
   assign dbg_rdata       = mem[dbg_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (aw_hs) state_d = DATA;
         DATA:    if (w_hs && last_beat) state_d = RESP;
         RESP:    if (b_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
         burst_q  <= '0;
         user_q   <= '0;
         cnt_q    <= '0;
         slverr_q <= 1'b0;
         decerr_q <= 1'b0;
      end else if (aw_hs) begin
         id_q     <= axi_slv_awid;
         addr_q   <= axi_slv_awaddr;
         len_q    <= axi_slv_awlen;
         size_q   <= axi_slv_awsize;
         burst_q  <= axi_slv_awburst;
         user_q   <= axi_slv_awuser;
         cnt_q    <= '0;
         decerr_q <= (axi_slv_awaddr >= MEM_BYTES);
         slverr_q <= (axi_slv_awburst >= AXI_BURST_W'(2)) ||
                     (axi_slv_awsize > AXI_SIZE_W'(ADDR_LSB));
      end else if (w_hs) begin
         cnt_q <= cnt_q + 1'b1;
         // wlast must coincide exactly with the counted final beat
         if (axi_slv_wlast != last_beat) slverr_q <= 1'b1;
         if (burst_q == AXI_BURST_W'(1))
            addr_q <= addr_q + (AXI_ADDR_W'(1) << size_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else if (w_hs && !slverr_q && !decerr_q) begin
         for (int b = 0; b < STRB_W; b++)
            if (axi_slv_wstrb[b]) mem[idx][b*8 +: 8] <= axi_slv_wdata[b*8 +: 8];
      end
   end

endmodule

// File: tb/tb_easyaxi_slv_wr_ctrl.sv
// Directed bench for easyaxi_slv_wr_ctrl: inputs driven and outputs sampled
// on the falling edge, with hand-computed expectations.
module tb_easyaxi_slv_wr_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        awvalid, awready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [3:0]  awuser;
   logic        wvalid, wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        bvalid, bready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic [3:0]  buser;
   logic [3:0]  dbg_addr;
   logic [31:0] dbg_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   easyaxi_slv_wr_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .axi_slv_awvalid(awvalid), .axi_slv_awready(awready),
      .axi_slv_awid(awid), .axi_slv_awaddr(awaddr), .axi_slv_awlen(awlen),
      .axi_slv_awsize(awsize), .axi_slv_awburst(awburst), .axi_slv_awuser(awuser),
      .axi_slv_wvalid(wvalid), .axi_slv_wready(wready), .axi_slv_wdata(wdata),
      .axi_slv_wstrb(wstrb), .axi_slv_wlast(wlast),
      .axi_slv_bvalid(bvalid), .axi_slv_bready(bready), .axi_slv_bid(bid),
      .axi_slv_bresp(bresp), .axi_slv_buser(buser),
      .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Present an AW request and return at the falling edge after its handshake.
   task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [3:0] user);
      int n = 0;
      awvalid = 1'b1; awid = id; awaddr = addr; awlen = len;
      awsize = 3'd2; awburst = burst; awuser = user;
      while (!awready && n < 50) begin @(negedge clk); n++; end
      if (!awready) begin
         errors++; $display("FAIL aw_timeout: awready=%0b required=1", awready);
      end
      @(negedge clk);
      awvalid = 1'b0;
   endtask

   // One W beat; returns at the falling edge after the beat is accepted.
   task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
      int n = 0;
      wvalid = 1'b1; wdata = data; wstrb = strb; wlast = last;
      while (!wready && n < 50) begin @(negedge clk); n++; end
      if (!wready) begin
         errors++; $display("FAIL w_timeout: wready=%0b required=1", wready);
      end
      @(negedge clk);
      wvalid = 1'b0;
   endtask

   // Wait for B, check its fields, handshake, and check AW reopens next cycle.
   task automatic do_b(input string tag, input logic [3:0] eid, input logic [1:0] eresp);
      int n = 0;
      while (!bvalid && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (bvalid !== 1'b1) begin
         errors++; $display("FAIL %s_bvalid: got %0b required 1", tag, bvalid);
      end
      checks++;
      if (bid !== eid || bresp !== eresp) begin
         errors++; $display("FAIL %s_b: bid=%0d bresp=%0d required bid=%0d bresp=%0d",
                            tag, bid, bresp, eid, eresp);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      checks++;
      if (awready !== 1'b1 || bvalid !== 1'b0) begin
         errors++; $display("FAIL %s_after_b: awready=%0b bvalid=%0b required 1/0",
                            tag, awready, bvalid);
      end
   endtask

   task automatic check_mem(input string tag, input logic [3:0] a, input logic [31:0] exp);
      dbg_addr = a;
      #1;
      checks++;
      if (dbg_rdata !== exp) begin
         errors++; $display("FAIL %s_mem[%0d]: got %h required %h", tag, a, dbg_rdata, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awuser = 0;
      wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0; dbg_addr = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({awready, wready, bvalid} !== 3'b100) begin
         errors++; $display("FAIL reset_hs: aw/w/b ready-valid=%b required 100",
                            {awready, wready, bvalid});
      end
      checks++;
      if ({bid, bresp, buser} !== 10'd0) begin
         errors++; $display("FAIL reset_b: bid=%0d bresp=%0d buser=%0d required 0",
                            bid, bresp, buser);
      end
      check_mem("reset", 4'd7, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      do_aw(4'd3, 32'h8, 8'd0, 2'd1, 4'd0);
      checks++;
      if (wready !== 1'b1 || awready !== 1'b0) begin
         errors++; $display("FAIL single_wready: wready=%0b awready=%0b required 1/0",
                            wready, awready);
      end
      do_w(32'hDEADBEEF, 4'hF, 1'b1);
      checks++;
      if (bvalid !== 1'b1) begin
         errors++; $display("FAIL single_b_latency: bvalid=%0b required 1", bvalid);
      end
      do_b("single", 4'd3, 2'd0);
      check_mem("single", 4'd2, 32'hDEADBEEF);
   endtask

   task automatic test_incr_burst();
      do_aw(4'd5, 32'h0, 8'd3, 2'd1, 4'd2);
      for (int i = 1; i <= 4; i++) begin
         checks++;
         if (awready !== 1'b0 || bvalid !== 1'b0) begin
            errors++; $display("FAIL incr_during_beat%0d: awready=%0b bvalid=%0b required 0/0",
                               i, awready, bvalid);
         end
         do_w(32'(i), 4'hF, i == 4);
      end
      checks++;
      if (buser !== 4'd2) begin
         errors++; $display("FAIL incr_buser: got %0d required 2", buser);
      end
      do_b("incr", 4'd5, 2'd0);
      for (int i = 0; i < 4; i++) check_mem("incr", 4'(i), 32'(i + 1));
   endtask

   task automatic test_strobe_fixed();
      do_aw(4'd1, 32'h14, 8'd0, 2'd1, 4'd0);
      do_w(32'hFFFFFFFF, 4'hF, 1'b1);
      do_b("prefill", 4'd1, 2'd0);
      check_mem("prefill", 4'd5, 32'hFFFFFFFF);
      do_aw(4'd2, 32'h14, 8'd1, 2'd0, 4'd0);
      do_w(32'h11223344, 4'h3, 1'b0);
      do_w(32'hAABBCCDD, 4'h8, 1'b1);
      do_b("fixed", 4'd2, 2'd0);
      check_mem("fixed", 4'd5, 32'hAAFF3344);
      check_mem("fixed_neighbor", 4'd6, 32'h0);
   endtask

   task automatic test_errors();
      do_aw(4'd4, 32'h40, 8'd0, 2'd1, 4'd0);
      do_w(32'h12345678, 4'hF, 1'b1);
      do_b("decerr", 4'd4, 2'd3);
      check_mem("decerr", 4'd0, 32'h1);
      do_aw(4'd6, 32'h4, 8'd0, 2'd2, 4'd0);
      do_w(32'h87654321, 4'hF, 1'b1);
      do_b("burst2", 4'd6, 2'd2);
      check_mem("burst2", 4'd1, 32'h2);
      do_aw(4'd7, 32'h18, 8'd1, 2'd1, 4'd0);
      do_w(32'hCAFE0001, 4'hF, 1'b1);
      checks++;
      if (bvalid !== 1'b0 || wready !== 1'b1) begin
         errors++; $display("FAIL early_wlast_hold: bvalid=%0b wready=%0b required 0/1",
                            bvalid, wready);
      end
      do_w(32'hCAFE0002, 4'hF, 1'b1);
      do_b("early_wlast", 4'd7, 2'd2);
   endtask

   task automatic test_backpressure();
      do_aw(4'd9, 32'h1C, 8'd0, 2'd1, 4'd1);
      do_w(32'h0BADF00D, 4'hF, 1'b1);
      awvalid = 1'b1; awid = 4'd10; awaddr = 32'h20; awlen = 8'd0;
      awsize = 3'd2; awburst = 2'd1; awuser = 4'd0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bvalid !== 1'b1 || bid !== 4'd9 || bresp !== 2'd0 || awready !== 1'b0) begin
            errors++; $display("FAIL bp_hold%0d: bvalid=%0b bid=%0d bresp=%0d awready=%0b required 1/9/0/0",
                               i, bvalid, bid, bresp, awready);
         end
         @(negedge clk);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      checks++;
      if (awready !== 1'b1 || bvalid !== 1'b0) begin
         errors++; $display("FAIL bp_release: awready=%0b bvalid=%0b required 1/0", awready, bvalid);
      end
      @(negedge clk);
      awvalid = 1'b0;
      checks++;
      if (wready !== 1'b1) begin
         errors++; $display("FAIL bp_new_aw: wready=%0b required 1", wready);
      end
      do_w(32'h5A5A5A5A, 4'hF, 1'b1);
      do_b("bp_second", 4'd10, 2'd0);
      check_mem("bp", 4'd7, 32'h0BADF00D);
      check_mem("bp", 4'd8, 32'h5A5A5A5A);
   endtask

   task automatic test_reset_mid_burst();
      do_aw(4'd11, 32'h24, 8'd3, 2'd1, 4'd0);
      do_w(32'h1111, 4'hF, 1'b0);
      do_w(32'h2222, 4'hF, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++;
      if (awready !== 1'b1 || bvalid !== 1'b0 || wready !== 1'b0) begin
         errors++; $display("FAIL rst_mid: awready=%0b bvalid=%0b wready=%0b required 1/0/0",
                            awready, bvalid, wready);
      end
      for (int i = 0; i < 16; i++) check_mem("rst_clear", 4'(i), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_aw(4'd12, 32'h3C, 8'd0, 2'd1, 4'd0);
      do_w(32'h600DCAFE, 4'hF, 1'b1);
      do_b("post_rst", 4'd12, 2'd0);
      check_mem("post_rst", 4'd15, 32'h600DCAFE);
   endtask

   initial begin
      test_reset();
      test_single();
      test_incr_burst();
      test_strobe_fixed();
      test_errors();
      test_backpressure();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
